imem_loader_rf_dump: RTL and testbench
======================================

// Module: imem_loader_rf_dump
// PURPOSE
//  Hardware counterpart of the bench load/run/check flow around Processor.
//  Streams a program into instruction memory, holds the core in reset while loading,
//  then releases the core for a fixed number of cycles and freezes it.
//  Finally reads GPR 1..31 via a read port and emits them on an output stream.
// PARAMETERS
//  ADDR_W  6   instruction-memory word-address width (depth 2**ADDR_W)
//  CYC_W   16  width of run-cycle counter
// PORTS
//  clk         in   1       system clock, all state updates on rising edge
//  reset       in   1       synchronous, active-high
//  start       in   1       begin a load/run/dump sequence (sampled in IDLE/DONE only)
//  num_words   in   ADDR_W+1 words to load (0..2**ADDR_W), latched on start
//  run_cycles  in   CYC_W   enabled core cycles, latched on start
//  in_valid    in   1       program word valid
//  in_ready    out  1       loader accepts program word
//  in_data     in   32      program word (instruction)
//  imem_we     out  1       instruction-memory write enable
//  imem_addr   out  ADDR_W  instruction-memory word address
//  imem_wdata  out  32      instruction-memory write data
//  proc_reset  out  1       core reset (active-high)
//  proc_en     out  1       core clock enable
//  rf_raddr    out  5       GPR read address
//  rf_rdata    in   32      GPR read data, combinational from rf_raddr
//  out_valid   out  1       dump word valid
//  out_ready   in   1       consumer accepts dump word
//  out_regnum  out  5       register index of out_data
//  out_data    out  32      register content
//  busy        out  1       state is LOAD, RUN or DUMP
//  done        out  1       state is DONE
// BEHAVIOUR
//  FSM states: IDLE, LOAD, RUN, DUMP, DONE.
//  Reset: state=IDLE; proc_reset=1; all other outputs 0; counters 0.
//  Reset mid-sequence: same values on the next edge; partial load abandoned.
//  Core controls: proc_reset=1 in IDLE/LOAD; 0 in RUN/DUMP/DONE.
//    proc_en=1 only in RUN.
//  IDLE/DONE + start: latch num_words and run_cycles; ptr=0; next state LOAD.
//    If num_words==0, go to RUN instead; if run_cycles is also 0, go to DUMP.
//  LOAD: in_ready=1.
//    imem_we = in_valid & in_ready (combinational); imem_addr=ptr; imem_wdata=in_data.
//    On each handshake ptr++. Handshake at ptr==num_words-1 -> RUN
//    (or DUMP if run_cycles==0).
//    in_ready=0 and imem_we=0 in every other state.
//  RUN: cyc counts enabled edges from 0. When cyc==run_cycles-1 -> DUMP.
//    Core therefore gets exactly run_cycles enabled edges.
//  DUMP: idx starts at 1.
//    rf_raddr=idx; out_valid=1; out_regnum=idx; out_data=rf_rdata.
//    out_valid/regnum/data hold stable until out_ready.
//    On handshake idx++. Handshake at idx==31 -> DONE. Exactly 31 words per sequence.
//  DONE: done=1, held until start or reset. start in LOAD/RUN/DUMP is ignored.
//  Zero-wait throughput: 1 word/cycle in LOAD and DUMP.
// TESTING
//  T1 reset 2 cycles -> proc_reset=1, in_ready=0, out_valid=0, busy=0, done=0.
//  T2 num_words=6, run_cycles=29, in_valid always 1
//     -> imem writes at addr 0..5 on 6 consecutive cycles;
//     -> proc_en high exactly 29 cycles;
//     -> 31 dump words, regnum 1..31, data matching the expected file.
//  T3 GPRs preset to 0xcafebabe, num_words=0, run_cycles=0
//     -> straight to DUMP; all 31 words = 0xcafebabe.
//  T4 random in_valid gaps and out_ready backpressure (50%)
//     -> no lost or duplicated word;
//     -> out_data stable while out_valid & !out_ready.
//  T5 reset asserted in RUN after 10 cycles -> next edge IDLE, proc_en=0, proc_reset=1.
//     A new start reloads from addr 0.
//  T6 start pulsed during DUMP -> ignored.
//     From DONE, start with num_words=2**ADDR_W -> full-depth load, last addr=2**ADDR_W-1.

Source files
------------

// File: rtl/imem_loader_rf_dump_if.sv
// Bundle between the program loader / register dump controller and its environment.
// The master side is the controller, the slave side is stream source, memory, core and sink.
interface imem_loader_rf_dump_if #(
   parameter int ADDR_W = 6,
   parameter int CYC_W  = 16
);
   logic              start;
   logic [ADDR_W:0]   num_words;
   logic [CYC_W-1:0]  run_cycles;

   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_data;

   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   logic              proc_reset;
   logic              proc_en;

   logic [4:0]        rf_raddr;
   logic [31:0]       rf_rdata;

   logic              out_valid;
   logic              out_ready;
   logic [4:0]        out_regnum;
   logic [31:0]       out_data;

   logic              busy;
   logic              done;

   modport master (
      input  start, num_words, run_cycles,
      input  in_valid, in_data,
      output in_ready,
      output imem_we, imem_addr, imem_wdata,
      output proc_reset, proc_en,
      output rf_raddr,
      input  rf_rdata,
      output out_valid, out_regnum, out_data,
      input  out_ready,
      output busy, done
   );

   modport slave (
      output start, num_words, run_cycles,
      output in_valid, in_data,
      input  in_ready,
      input  imem_we, imem_addr, imem_wdata,
      input  proc_reset, proc_en,
      input  rf_raddr,
      output rf_rdata,
      input  out_valid, out_regnum, out_data,
      output out_ready,
      input  busy, done
   );
endinterface

// File: rtl/imem_loader_rf_dump.sv
// Loads a program into instruction memory, runs the core for a fixed
// number of enabled cycles, then streams out GPR 1..31.
module imem_loader_rf_dump #(
   parameter int ADDR_W = 6,
   parameter int CYC_W  = 16
) (
   input  logic clk,
   input  logic reset,
   imem_loader_rf_dump_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DUMP,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0]  NW_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
   localparam logic [4:0]       IDX_LAST = 5'd31;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   nw_q, nw_d;
   logic [CYC_W-1:0]  rc_q, rc_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic [4:0]        idx_q, idx_d;

   logic in_ready_q, in_ready_d;
   logic out_valid_q, out_valid_d;
   logic proc_reset_q, proc_reset_d;
   logic proc_en_q, proc_en_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic load_hs;
   logic dump_hs;

   assign load_hs = bus.in_valid & in_ready_q;
   assign dump_hs = out_valid_q & bus.out_ready;

   always_comb begin
      state_d = state_q;
      nw_d    = nw_q;
      rc_d    = rc_q;
      ptr_d   = ptr_q;
      cyc_d   = cyc_q;
      idx_d   = idx_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               nw_d  = bus.num_words;
               rc_d  = bus.run_cycles;
               ptr_d = '0;
               cyc_d = '0;
               idx_d = 5'd1;
               if (bus.num_words != '0)
                  state_d = S_LOAD;
               else if (bus.run_cycles != '0)
                  state_d = S_RUN;
               else
                  state_d = S_DUMP;
            end
         end
         S_LOAD: begin
            if (load_hs) begin
               ptr_d = ptr_q + 1'b1;
               if ({1'b0, ptr_q} == nw_q - NW_ONE)
                  state_d = (rc_q == '0) ? S_DUMP : S_RUN;
            end
         end
         S_RUN: begin
            cyc_d = cyc_q + CYC_ONE;
            if (cyc_q == rc_q - CYC_ONE)
               state_d = S_DUMP;
         end
         S_DUMP: begin
            if (dump_hs) begin
               idx_d = idx_q + 5'd1;
               if (idx_q == IDX_LAST)
                  state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Status/control outputs are registered from the next state.
      in_ready_d   = (state_d == S_LOAD);
      out_valid_d  = (state_d == S_DUMP);
      proc_reset_d = (state_d == S_IDLE) || (state_d == S_LOAD);
      proc_en_d    = (state_d == S_RUN);
      busy_d       = (state_d == S_LOAD) || (state_d == S_RUN) ||
                     (state_d == S_DUMP);
      done_d       = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         nw_q         <= '0;
         rc_q         <= '0;
         ptr_q        <= '0;
         cyc_q        <= '0;
         idx_q        <= '0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         proc_reset_q <= 1'b1;
         proc_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         nw_q         <= nw_d;
         rc_q         <= rc_d;
         ptr_q        <= ptr_d;
         cyc_q        <= cyc_d;
         idx_q        <= idx_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         proc_reset_q <= proc_reset_d;
         proc_en_q    <= proc_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = load_hs;
   assign bus.imem_addr  = ptr_q;
   assign bus.imem_wdata = bus.in_data;
   assign bus.proc_reset = proc_reset_q;
   assign bus.proc_en    = proc_en_q;
   assign bus.rf_raddr   = idx_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_regnum = idx_q;
   assign bus.out_data   = bus.rf_rdata;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_imem_loader_rf_dump.sv
// Randomised scoreboard bench: toy core + register file around the loader,
// expected imem writes and dump words come from a high-level model.
module tb_imem_loader_rf_dump;
   localparam int ADDR_W = 6;
   localparam int CYC_W  = 16;
   localparam int DEPTH  = 64;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   imem_loader_rf_dump_if #(.ADDR_W(ADDR_W), .CYC_W(CYC_W)) ifc ();

   imem_loader_rf_dump #(.ADDR_W(ADDR_W), .CYC_W(CYC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Environment: instruction memory, register file and a toy core that
   // adds imem[pc % DEPTH] into GPR (pc % 31)+1 on each enabled edge.
   logic [31:0] imem [DEPTH];
   logic [31:0] rf [32];
   int          core_pc;
   logic        env_init;
   logic        preset_go;
   logic [31:0] preset_val;

   always @(posedge clk) begin
      if (env_init) begin
         for (int i = 0; i < DEPTH; i++) imem[i] <= '0;
      end else if (ifc.imem_we) begin
         imem[ifc.imem_addr] <= ifc.imem_wdata;
      end
      if (env_init) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (preset_go) begin
         for (int i = 1; i < 32; i++) rf[i] <= preset_val;
      end else if (!ifc.proc_reset && ifc.proc_en) begin
         rf[core_pc % 31 + 1] <= rf[core_pc % 31 + 1] + imem[core_pc % DEPTH];
      end
      if (ifc.proc_reset) core_pc <= 0;
      else if (ifc.proc_en) core_pc <= core_pc + 1;
   end

   assign ifc.rf_rdata = rf[ifc.rf_raddr];

   // Reference model state
   logic [31:0] ref_imem [DEPTH];
   logic [31:0] ref_rf [32];
   int          ref_pc;
   bit          fresh;

   typedef struct packed { logic [5:0] a; logic [31:0] d; } wr_t;
   typedef struct packed { logic [4:0] r; logic [31:0] d; } dump_t;
   wr_t   wr_q[$];
   dump_t dump_q[$];

   int pen_cnt, rdy_cnt, dump_cyc;
   bit bp;

   // Monitor
   initial begin
      bit          pend;
      logic [4:0]  p_r;
      logic [31:0] p_d;
      wr_t         w;
      dump_t       e;
      pend = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend = 0;
         end else begin
            if (ifc.proc_en) pen_cnt++;
            if (ifc.in_ready) rdy_cnt++;
            if (ifc.imem_we) begin
               if (wr_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL imem_unexpected: write addr %0d", ifc.imem_addr);
               end else begin
                  w = wr_q.pop_front();
                  chk("imem_addr", 64'(ifc.imem_addr), 64'(w.a));
                  chk("imem_data", 64'(ifc.imem_wdata), 64'(w.d));
               end
            end
            if (ifc.out_valid) begin
               dump_cyc++;
               if (pend) begin
                  chk("hold_regnum", 64'(ifc.out_regnum), 64'(p_r));
                  chk("hold_data", 64'(ifc.out_data), 64'(p_d));
               end
               if (ifc.out_ready) begin
                  pend = 0;
                  if (dump_q.size() == 0) begin
                     n_chk++;
                     $display("FAIL dump_unexpected: reg %0d", ifc.out_regnum);
                  end else begin
                     e = dump_q.pop_front();
                     chk("dump_regnum", 64'(ifc.out_regnum), 64'(e.r));
                     chk("dump_data", 64'(ifc.out_data), 64'(e.d));
                  end
               end else begin
                  pend = 1;
                  p_r = ifc.out_regnum;
                  p_d = ifc.out_data;
               end
            end else begin
               pend = 0;
            end
         end
      end
   end

   // Sink backpressure
   initial begin
      ifc.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 ifc.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic preset(input logic [31:0] v);
      preset_val = v;
      preset_go = 1'b1;
      @(posedge clk);
      #1 preset_go = 1'b0;
      for (int i = 1; i < 32; i++) ref_rf[i] = v;
   endtask

   task automatic do_start(input int nw, input int rc);
      @(posedge clk);
      #1;
      ifc.start = 1'b1;
      ifc.num_words = (ADDR_W+1)'(nw);
      ifc.run_cycles = CYC_W'(rc);
      pen_cnt = 0;
      rdy_cnt = 0;
      dump_cyc = 0;
      @(posedge clk);
      #1 ifc.start = 1'b0;
   endtask

   task automatic feed(input int nw, input bit gaps, input logic [31:0] prog[DEPTH]);
      int i;
      int t;
      bit hs;
      i = 0;
      t = 0;
      while (i < nw && t < 2000) begin
         ifc.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         ifc.in_data = prog[i];
         @(negedge clk);
         hs = ifc.in_valid && ifc.in_ready;
         @(posedge clk);
         #1;
         if (hs) i++;
         t++;
      end
      ifc.in_valid = 1'b0;
      chk("load_complete", 64'(i), 64'(nw));
   endtask

   task automatic gen_prog(input int nw, output logic [31:0] prog[DEPTH]);
      for (int i = 0; i < DEPTH; i++) prog[i] = '0;
      for (int i = 0; i < nw; i++) begin
         prog[i] = $urandom;
         ref_imem[i] = prog[i];
         wr_q.push_back({6'(i), prog[i]});
      end
   endtask

   task automatic run_seq(input int nw, input int rc, input bit gaps,
                          input bit bp_on, input bit poke);
      logic [31:0] prog [DEPTH];
      int t;
      bit poked;
      if (nw > 0 || fresh) ref_pc = 0;
      fresh = 0;
      gen_prog(nw, prog);
      for (int c = 0; c < rc; c++) begin
         ref_rf[ref_pc % 31 + 1] = ref_rf[ref_pc % 31 + 1] + ref_imem[ref_pc % DEPTH];
         ref_pc++;
      end
      for (int r = 1; r < 32; r++) dump_q.push_back({5'(r), ref_rf[r]});
      bp = bp_on;
      do_start(nw, rc);
      feed(nw, gaps, prog);
      t = 0;
      poked = 0;
      while (!ifc.done && t < 5000) begin
         if (poke && !poked && ifc.out_valid) begin
            ifc.start = 1'b1;
            ifc.num_words = 7'd5;
            ifc.run_cycles = 16'd3;
            poked = 1;
         end
         @(posedge clk);
         #1 ifc.start = 1'b0;
         t++;
      end
      bp = 0;
      chk("reached_done", 64'(ifc.done), 64'd1);
      chk("proc_en_cycles", 64'(pen_cnt), 64'(rc));
      chk("busy_in_done", 64'(ifc.busy), 64'd0);
      chk("proc_reset_in_done", 64'(ifc.proc_reset), 64'd0);
      chk("dump_words_left", 64'(dump_q.size()), 64'd0);
      chk("imem_writes_left", 64'(wr_q.size()), 64'd0);
      if (!gaps) chk("load_cycles", 64'(rdy_cnt), 64'(nw));
      if (!bp_on) chk("dump_cycles", 64'(dump_cyc), 64'd31);
   endtask

   initial begin
      logic [31:0] prog [DEPTH];
      int t;
      ifc.start = 1'b0;
      ifc.num_words = '0;
      ifc.run_cycles = '0;
      ifc.in_valid = 1'b0;
      ifc.in_data = '0;
      bp = 0;
      preset_go = 1'b0;
      preset_val = '0;
      env_init = 1'b1;
      fresh = 1;
      ref_pc = 0;
      for (int i = 0; i < DEPTH; i++) ref_imem[i] = '0;
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;

      // T1 reset
      repeat (2) @(posedge clk);
      #1 env_init = 1'b0;
      @(negedge clk);
      chk("rst_proc_reset", 64'(ifc.proc_reset), 64'd1);
      chk("rst_in_ready", 64'(ifc.in_ready), 64'd0);
      chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
      chk("rst_busy", 64'(ifc.busy), 64'd0);
      chk("rst_done", 64'(ifc.done), 64'd0);
      chk("rst_proc_en", 64'(ifc.proc_en), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // T2 basic load/run/dump
      run_seq(6, 29, 0, 0, 0);

      // T3 preset GPRs, nothing loaded, no run cycles
      preset(32'hcafebabe);
      run_seq(0, 0, 0, 0, 0);

      // T4 random gaps and backpressure
      for (int k = 0; k < 3; k++)
         run_seq($urandom_range(1, 20), $urandom_range(1, 80), 1, 1, 0);

      // T5 reset while running
      gen_prog(4, prog);
      do_start(4, 100);
      feed(4, 0, prog);
      t = 0;
      while (!ifc.proc_en && t < 100) begin
         @(posedge clk);
         #1 t++;
      end
      chk("t5_running", 64'(ifc.proc_en), 64'd1);
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t5_proc_en", 64'(ifc.proc_en), 64'd0);
      chk("t5_proc_reset", 64'(ifc.proc_reset), 64'd1);
      chk("t5_busy", 64'(ifc.busy), 64'd0);
      chk("t5_done", 64'(ifc.done), 64'd0);
      chk("t5_out_valid", 64'(ifc.out_valid), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      fresh = 1;
      preset($urandom);
      run_seq(5, 40, 1, 1, 0);

      // T6 start during DUMP ignored, then full-depth load from DONE
      run_seq(3, 7, 0, 1, 1);
      run_seq(DEPTH, 70, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
